fc_weight_fetch_ctrl: RTL and testbench
=======================================

# fc_weight_fetch_ctrl

Sequencer for the SE-block fully-connected weight memory: the two-bank store of 32768 + 1256 rows, 32 × 14-bit lanes per row. It accepts a job (mode, global start row, row count), then streams row writes from a loader or row reads to the FC datapath. It drives the memory's local index, en, rd and wr. It also keeps a mirror of the memory's internal bank select, which flips whenever the memory's active bank sees its last index, and it forces bank flips when a job starts in the other bank.

## Interface
- H1, 32768, rows in bank 0
- H2, 1256, rows in bank 1
- AW, 16, global row address / count width (covers H1+H2 = 34024)
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset; asserted in the same cycles as the memory's reset
- start  in  1  job request, sampled only in IDLE
- mode  in  1  0 = read job, 1 = write job
- base  in  AW  global start row (bank 0 rows 0..H1-1, bank 1 rows H1..H1+H2-1)
- count  in  AW  rows in job
- wr_valid  in  1  loader has a row on the memory data_in bus
- wr_ready  out  1  controller accepts a row this cycle
- rd_ready  in  1  consumer can take a row one cycle later
- out_valid  out  1  memory data_out holds a requested row this cycle
- out_last  out  1  with out_valid: final row of job
- mem_index  out  15  local row index to memory
- mem_en, mem_rd, mem_wr  out  1 each  memory strobes
- bank  out  1  mirror of memory bank select
- busy  out  1  job in progress (not IDLE)
- done  out  1  one-cycle pulse at job completion
- err  out  1  one-cycle pulse: job rejected

## Operation
- Reset: state IDLE. All outputs are 0, including bank, mem_index and every strobe. Row counter and address are cleared.
- FSM states: IDLE, FLIP, RUN, DRAIN, DONE.
- **IDLE**
  - mem_index = 0 and strobes are 0.
  - On start, reject the job if count == 0 or base + count > H1+H2, computed AW+1 bits wide. On reject: pulse err the next cycle and stay in IDLE.
  - Otherwise latch mode, base and count. The target bank is base ≥ H1.
  - Go to FLIP if the target bank ≠ bank, else go to RUN.
- **FLIP** (exactly 1 cycle)
  - Drive mem_index = H1-1 if bank = 0, or H2-1 if bank = 1. en, rd and wr stay 0.
  - Toggle bank, then go to RUN.
- **RUN**
  - mem_index = global address − (bank ? H1 : 0).
  - Read mode: issue when rd_ready = 1, driving mem_en = mem_rd = 1.
  - Write mode: wr_ready = 1 and issue when wr_valid = 1, driving mem_en = mem_wr = mem_wr_ready·wr_valid.
  - No issue means no strobes, and the index is held.
  - Each issue increments the address and decrements the remaining count.
  - Bank crossing: issuing global row H1-1 while bank = 0 toggles bank in that cycle. This matches the memory's own flip.
  - Issuing the last row: read → DRAIN; write → DONE.
- **DRAIN**: one cycle so the last read returns. Strobes are 0 and mem_index = 0. Then go to DONE.
- **DONE**: done = 1 for one cycle, then IDLE.
- The controller never drives the last index of the active bank except when it intends a flip: in FLIP, or on a genuinely requested row.
- start while busy is ignored: no err, no effect.
- rst mid-job: return to IDLE immediately with outputs 0. An out_valid for a read already in flight is dropped. bank returns to 0, consistent with the memory reset.

## Timing
- Memory read latency is 1 cycle. out_valid and out_last are registered copies of the read issue and last-row flag.
- Consumer rule: rd_ready high at cycle t guarantees acceptance at t+1. There is no backpressure on out_valid.
- start accepted at t:
  - RUN at t+1, or FLIP at t+1 and RUN at t+2.
  - Earliest first strobe is t+1, or t+2 when a flip is needed.
- Read job of N rows with rd_ready held high from RUN entry:
  - strobes are continuous for N cycles;
  - last out_valid is in the DRAIN cycle;
  - done comes the following cycle.
- Write job: done comes the cycle after the last accepted wr_valid.
- err comes at t+1 after a rejected start.

## Test plan
- Reset, then read job base=0, count=4, rd_ready=1 → mem_index 0,1,2,3 on 4 consecutive cycles with rd=en=1. out_valid on the next 4 cycles, out_last on the 4th. done 1 cycle later. bank stays 0.
- Write job base=H1-2, count=4, wr_valid=1 → mem_index H1-2, H1-1, 0, 1. bank rises in the cycle index H1-1 is driven. wr strobes on all 4 cycles. Final bank = 1.
- With bank=1, read job base=5, count=1 → FLIP cycle with mem_index=H2-1 and strobes 0. bank returns to 0. Next cycle mem_index=5 with rd=1.
- Read job count=8 with rd_ready toggling 1,0,1,0… → exactly 8 rd strobes. Index held on idle cycles. Exactly 8 out_valid, each one cycle after its issue.
- Reject checks: start with count=0 → err pulse at t+1, no strobes. Start with base=34020, count=5 → err. start while busy → ignored.
- rst asserted mid-read at row 10 of 20 → the next cycle shows all outputs 0 and IDLE. A new job starting at row 0 then runs normally.

Source files
------------

// File: rtl/fc_weight_fetch_ctrl.sv
// Job sequencer for the two-bank SE-block FC weight memory: streams loader writes or
// datapath reads, drives the memory strobes and mirrors the memory's bank select.
module fc_weight_fetch_ctrl #(
    parameter int H1 = 32768,
    parameter int H2 = 1256,
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] base,
    input  logic [AW-1:0] count,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic          rd_ready,
    output logic          out_valid,
    output logic          out_last,
    output logic [14:0]   mem_index,
    output logic          mem_en,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic          bank,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLIP,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [AW:0] TOTAL_ROWS = (AW+1)'(H1 + H2);

    state_t        state_q, state_d;
    logic          mode_q, mode_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] remain_q, remain_d;
    logic          bank_q, bank_d;
    logic          err_q, err_d;
    logic          out_valid_q, out_last_q;

    logic          issue;
    logic          reject;
    logic          target_bank;
    logic [AW:0]   end_row;
    logic [14:0]   local_addr;
    logic [14:0]   last_local;
    logic          at_last;

    // Job legality is judged one bit wider so base + count cannot wrap.
    assign end_row     = {1'b0, base} + {1'b0, count};
    assign reject      = (count == '0) || (end_row > TOTAL_ROWS);
    assign target_bank = (base >= AW'(H1));
    assign local_addr  = 15'(addr_q - (bank_q ? AW'(H1) : AW'(0)));
    assign last_local  = bank_q ? 15'(H2 - 1) : 15'(H1 - 1);
    assign at_last     = (local_addr == last_local);

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves one
        // unassigned and no latch is inferred.
        state_d   = state_q;
        mode_d    = mode_q;
        addr_d    = addr_q;
        remain_d  = remain_q;
        bank_d    = bank_q;
        err_d     = 1'b0;
        issue     = 1'b0;
        wr_ready  = 1'b0;
        mem_index = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (reject) begin
                        err_d = 1'b1;
                    end else begin
                        mode_d   = mode;
                        addr_d   = base;
                        remain_d = count;
                        state_d  = (target_bank != bank_q) ? S_FLIP : S_RUN;
                    end
                end
            end
            S_FLIP: begin
                // Presenting the active bank's last index makes the memory flip its bank.
                mem_index = last_local;
                bank_d    = ~bank_q;
                state_d   = S_RUN;
            end
            S_RUN: begin
                wr_ready = mode_q;
                issue    = mode_q ? wr_valid : rd_ready;
                // A stalled cycle parked on the bank's last index would flip the memory.
                mem_index = (issue || !at_last) ? local_addr : '0;
                if (issue) begin
                    addr_d   = addr_q + 1'b1;
                    remain_d = remain_q - 1'b1;
                    if (at_last) begin
                        bank_d = ~bank_q;
                    end
                    if (remain_q == AW'(1)) begin
                        state_d = mode_q ? S_DONE : S_DRAIN;
                    end
                end
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples the
        // pre-edge values regardless of statement order.
        if (rst) begin
            state_q     <= S_IDLE;
            mode_q      <= 1'b0;
            addr_q      <= '0;
            remain_q    <= '0;
            bank_q      <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            addr_q      <= addr_d;
            remain_q    <= remain_d;
            bank_q      <= bank_d;
            err_q       <= err_d;
            out_valid_q <= issue & ~mode_q;
            out_last_q  <= issue & ~mode_q & (remain_q == AW'(1));
        end
    end

    assign mem_en    = issue;
    assign mem_rd    = issue & ~mode_q;
    assign mem_wr    = issue & mode_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign bank      = bank_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign err       = err_q;

endmodule

// File: tb/tb_fc_weight_fetch_ctrl.sv
// Scoreboard bench for fc_weight_fetch_ctrl: directed jobs push expected strobes,
// returned rows and done events; a negedge monitor pops and compares them.
module tb_fc_weight_fetch_ctrl;

    localparam int H1 = 32768;
    localparam int H2 = 1256;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic [AW-1:0] base = '0;
    logic [AW-1:0] count = '0;
    logic          wr_valid = 1'b0;
    logic          rd_ready = 1'b0;
    logic          wr_ready, out_valid, out_last;
    logic [14:0]   mem_index;
    logic          mem_en, mem_rd, mem_wr, bank, busy, done, err;

    fc_weight_fetch_ctrl #(.H1(H1), .H2(H2), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .base(base), .count(count),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .rd_ready(rd_ready),
        .out_valid(out_valid), .out_last(out_last), .mem_index(mem_index),
        .mem_en(mem_en), .mem_rd(mem_rd), .mem_wr(mem_wr), .bank(bank),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [14:0] idx;
        logic        last;
    } strobe_t;

    strobe_t exp_strobe_q[$];
    logic    exp_out_q[$];
    logic    exp_done_q[$];
    int      n_cmp = 0;
    int      n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [14:0] local_idx(input int g);
        return (g >= H1) ? 15'(g - H1) : 15'(g);
    endfunction

    task automatic push_job(input logic wr, input int gbase, input int n);
        strobe_t e;
        for (int i = 0; i < n; i++) begin
            e.rd   = ~wr;
            e.wr   = wr;
            e.idx  = local_idx(gbase + i);
            e.last = (i == n - 1);
            exp_strobe_q.push_back(e);
            if (!wr) exp_out_q.push_back(i == n - 1);
        end
        exp_done_q.push_back(1'b1);
    endtask

    task automatic do_start(input logic m, input int b, input int c);
        mode  = m;
        base  = AW'(b);
        count = AW'(c);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("job_timeout_busy", {31'b0, busy}, 0);
        tick();
    endtask

    function automatic logic [31:0] all_outputs();
        return {11'b0, wr_ready, out_valid, out_last, mem_index, mem_en, mem_rd, mem_wr,
                bank, busy, done, err};
    endfunction

    // Monitor: compares every strobe, returned row and done pulse against the queues.
    initial begin
        logic    prev_rd = 1'b0;
        logic    prev_fin = 1'b0;
        logic    cur_rd, cur_fin, el;
        strobe_t e;
        forever begin
            @(negedge clk);
            cur_rd  = 1'b0;
            cur_fin = 1'b0;
            if (out_valid) begin
                check("out_valid_after_issue", {31'b0, prev_rd}, 1);
                if (exp_out_q.size() == 0) begin
                    check("out_valid_unexpected", {31'b0, out_valid}, 0);
                end else begin
                    el = exp_out_q.pop_front();
                    check("out_last", {31'b0, out_last}, {31'b0, el});
                    cur_fin = out_last;
                end
            end else if (out_last) begin
                check("out_last_without_valid", {31'b0, out_last}, 0);
            end
            if (mem_en || mem_rd || mem_wr) begin
                if (exp_strobe_q.size() == 0) begin
                    check("strobe_unexpected", {31'b0, mem_en | mem_rd | mem_wr}, 0);
                end else begin
                    e = exp_strobe_q.pop_front();
                    check("strobe_en_rd_wr_index", {14'b0, mem_en, mem_rd, mem_wr, mem_index},
                          {14'b0, 1'b1, e.rd, e.wr, e.idx});
                    cur_rd = mem_rd;
                    if (e.wr && e.last) cur_fin = 1'b1;
                end
            end
            if (done) begin
                if (exp_done_q.size() == 0) begin
                    check("done_unexpected", {31'b0, done}, 0);
                end else begin
                    void'(exp_done_q.pop_front());
                    check("done_follows_last_row", {31'b0, prev_fin}, 1);
                end
            end
            prev_rd  = cur_rd;
            prev_fin = cur_fin;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int      n_iss;
        logic    found;
        strobe_t e;

        // Reset state
        tick();
        tick();
        @(negedge clk);
        check("reset_outputs_zero", all_outputs(), 0);
        tick();
        rst = 1'b0;

        // Read job base=0 count=4, rd_ready held high
        rd_ready = 1'b1;
        push_job(1'b0, 0, 4);
        do_start(1'b0, 0, 4);
        @(negedge clk);
        check("read_first_strobe_t1", {16'b0, mem_en, mem_index}, {16'b0, 1'b1, 15'd0});
        wait_idle(30);
        check("bank_after_read0", {31'b0, bank}, 0);

        // Write job across the bank boundary
        rd_ready = 1'b0;
        wr_valid = 1'b1;
        push_job(1'b1, H1 - 2, 4);
        do_start(1'b1, H1 - 2, 4);
        @(negedge clk);
        check("write_first_bank0", {15'b0, wr_ready, bank}, {15'b0, 1'b1, 1'b0});
        wait_idle(30);
        wr_valid = 1'b0;
        check("bank_after_cross", {31'b0, bank}, 1);

        // Read job in bank 0 while bank=1 forces a FLIP cycle
        rd_ready = 1'b1;
        push_job(1'b0, 5, 1);
        do_start(1'b0, 5, 1);
        @(negedge clk);
        check("flip_index", {17'b0, mem_index}, H2 - 1);
        check("flip_strobes_bank", {28'b0, mem_en, mem_rd, mem_wr, bank}, 1);
        @(negedge clk);
        check("bank_after_flip", {31'b0, bank}, 0);
        wait_idle(30);

        // Read job count=8 with rd_ready toggling
        push_job(1'b0, 100, 8);
        do_start(1'b0, 100, 8);
        n_iss = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (!busy) break;
            if (n_iss < 8) begin
                if (mem_en) n_iss++;
                else check("stall_index_held", {17'b0, mem_index}, 100 + n_iss);
            end
            @(posedge clk);
            #1;
            rd_ready = ~rd_ready;
        end
        tick();
        rd_ready = 1'b0;
        check("toggle_issue_count", n_iss, 8);

        // Rejected jobs
        do_start(1'b0, 0, 0);
        @(negedge clk);
        check("err_count_zero", {30'b0, err, busy}, 2);
        @(negedge clk);
        check("err_one_cycle", {31'b0, err}, 0);
        tick();
        do_start(1'b0, 34020, 5);
        @(negedge clk);
        check("err_overrun", {30'b0, err, busy}, 2);
        tick();

        // Largest legal job ending on the last row of bank 1
        rd_ready = 1'b1;
        push_job(1'b0, 34020, 4);
        do_start(1'b0, 34020, 4);
        @(negedge clk);
        check("flip_to_bank1_index", {17'b0, mem_index}, H1 - 1);
        wait_idle(30);

        // start while busy is ignored
        rd_ready = 1'b0;
        push_job(1'b0, 200, 2);
        do_start(1'b0, 200, 2);
        count = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        check("start_while_busy_no_err", {30'b0, err, busy}, 1);
        tick();
        rd_ready = 1'b1;
        wait_idle(30);

        // Reset in the middle of a 20-row read
        for (int i = 0; i <= 10; i++) begin
            e.rd   = 1'b1;
            e.wr   = 1'b0;
            e.idx  = 15'(i);
            e.last = 1'b0;
            exp_strobe_q.push_back(e);
            if (i < 10) exp_out_q.push_back(1'b0);
        end
        do_start(1'b0, 0, 20);
        found = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (mem_en && mem_index == 15'd10) begin
                found = 1'b1;
                break;
            end
        end
        check("reached_row10", {31'b0, found}, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rd_ready = 1'b0;
        @(negedge clk);
        check("mid_job_reset_outputs_zero", all_outputs(), 0);
        tick();

        // Fresh job after reset
        rd_ready = 1'b1;
        push_job(1'b0, 0, 3);
        do_start(1'b0, 0, 3);
        wait_idle(30);
        rd_ready = 1'b0;
        check("bank_after_reset_job", {31'b0, bank}, 0);

        tick();
        tick();
        check("strobe_queue_drained", exp_strobe_q.size(), 0);
        check("out_queue_drained", exp_out_q.size(), 0);
        check("done_queue_drained", exp_done_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
